ground_state_scroller: RTL and testbench

Horizontal scroll-position generator for the ground strip of the runner game. It is clocked by the 100 Hz game tick and advances a wrapping 16-bit x-offset into the ground texture by the current scroll speed on every running tick. Scroll speed starts at a preset value and accelerates at a fixed interval, saturating at a maximum. The renderer reads `ground_x` to draw the ground, and the game FSM reads `speed` and `wrap` for pacing.

---
 rtl/ground_state_scroller.sv | 93 +++++++++
 tb/tb_ground_state_scroller.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ground_state_scroller.sv
// ground_state_scroller: wrapping ground x-offset generator
// with a saturating, periodically accelerating scroll speed.
module ground_state_scroller #(
  parameter int GROUND_WIDTH = 1200,
  parameter int SPEED_INIT   = 2,
  parameter int SPEED_MAX    = 15,
  parameter int ACCEL_TICKS  = 1000
) (
  input  logic        clk_100Hz,
  input  logic        rst,
  input  logic        run,
  output logic [15:0] ground_x,
  output logic [3:0]  speed,
  output logic        wrap
);

  localparam int CW =
    (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

  localparam logic [CW-1:0] ACC_LAST =
    CW'(ACCEL_TICKS - 1);
  localparam logic [16:0] GW17 =
    17'(GROUND_WIDTH);
  localparam logic [3:0] SMAX =
    4'(SPEED_MAX);
  localparam logic [3:0] SINIT =
    4'(SPEED_INIT);

  logic [15:0]   r_x;
  logic [3:0]    r_speed;
  logic [CW-1:0] r_acc;
  logic          r_wrap;

  logic [16:0]   w_sum;
  logic          w_wrap;
  logic [15:0]   w_x_next;
  logic          w_acc_last;
  logic [3:0]    w_speed_inc;
  logic [CW-1:0] w_acc_next;

  // Full-width step and wrap compare, plus the
  // saturating speed increment and accel counter step.
  always_comb begin
    w_sum       = {1'b0, r_x} + {13'd0, r_speed};
    w_wrap      = (w_sum >= GW17);
    w_x_next    = w_sum[15:0];
    if (w_wrap) begin
      w_x_next  = 16'(w_sum - GW17);
    end
    w_acc_last  = (r_acc == ACC_LAST);
    w_acc_next  = r_acc + CW'(1);
    if (w_acc_last) begin
      w_acc_next = '0;
    end
    w_speed_inc = r_speed + 4'd1;
    if (r_speed >= SMAX) begin
      w_speed_inc = SMAX;
    end
  end

  // Position and wrap pulse: advance on running ticks,
  // wrap pulse clears on every other tick.
  always_ff @(posedge clk_100Hz) begin
    if (rst) begin
      r_x    <= '0;
      r_wrap <= 1'b0;
    end else if (run) begin
      r_x    <= w_x_next;
      r_wrap <= w_wrap;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  // Acceleration: count running ticks and bump speed
  // once per interval; progress holds while frozen.
  always_ff @(posedge clk_100Hz) begin
    if (rst) begin
      r_acc   <= '0;
      r_speed <= SINIT;
    end else if (run) begin
      r_acc <= w_acc_next;
      if (w_acc_last) begin
        r_speed <= w_speed_inc;
      end
    end
  end

  assign ground_x = r_x;
  assign speed    = r_speed;
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_ground_state_scroller.sv
// tb_ground_state_scroller: directed test-plan scenarios
// plus randomized run/reset traffic against a tick model.
module tb_ground_state_scroller;

  logic        clk = 1'b0;
  logic        rst_v [4];
  logic        run_v [4];
  logic [15:0] gx [4];
  logic [3:0]  sp [4];
  logic        wr [4];

  int tests = 0;
  int fails = 0;

  int mx [4];
  int mt [4];
  int mw [4];

  always #5 clk = ~clk;

  ground_state_scroller u0 (
    .clk_100Hz(clk), .rst(rst_v[0]), .run(run_v[0]),
    .ground_x(gx[0]), .speed(sp[0]), .wrap(wr[0])
  );

  ground_state_scroller #(
    .GROUND_WIDTH(10), .SPEED_INIT(3)
  ) u1 (
    .clk_100Hz(clk), .rst(rst_v[1]), .run(run_v[1]),
    .ground_x(gx[1]), .speed(sp[1]), .wrap(wr[1])
  );

  ground_state_scroller #(
    .ACCEL_TICKS(1), .SPEED_INIT(14)
  ) u2 (
    .clk_100Hz(clk), .rst(rst_v[2]), .run(run_v[2]),
    .ground_x(gx[2]), .speed(sp[2]), .wrap(wr[2])
  );

  ground_state_scroller #(
    .GROUND_WIDTH(37), .SPEED_INIT(0),
    .SPEED_MAX(9), .ACCEL_TICKS(5)
  ) u3 (
    .clk_100Hz(clk), .rst(rst_v[3]), .run(run_v[3]),
    .ground_x(gx[3]), .speed(sp[3]), .wrap(wr[3])
  );

  function automatic int p_gw(int d);
    case (d)
      1: return 10;
      3: return 37;
      default: return 1200;
    endcase
  endfunction

  function automatic int p_si(int d);
    case (d)
      1: return 3;
      2: return 14;
      3: return 0;
      default: return 2;
    endcase
  endfunction

  function automatic int p_sm(int d);
    return (d == 3) ? 9 : 15;
  endfunction

  function automatic int p_at(int d);
    case (d)
      2: return 1;
      3: return 5;
      default: return 1000;
    endcase
  endfunction

  // speed after t running ticks since reset
  function automatic int m_speed(int d, int t);
    int v;
    v = p_si(d) + t / p_at(d);
    return (v > p_sm(d)) ? p_sm(d) : v;
  endfunction

  task automatic step();
    int n;
    @(posedge clk);
    for (int d = 0; d < 4; d++) begin
      if (rst_v[d]) begin
        mx[d] = 0; mt[d] = 0; mw[d] = 0;
      end else if (run_v[d]) begin
        n = mx[d] + m_speed(d, mt[d]);
        mw[d] = (n >= p_gw(d)) ? 1 : 0;
        mx[d] = n % p_gw(d);
        mt[d]++;
      end else begin
        mw[d] = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    for (int d = 0; d < 4; d++) begin
      rst_v[d] = 1'b1;
      run_v[d] = 1'b0;
    end
    step();
    for (int d = 0; d < 4; d++) rst_v[d] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (gx[0] !== 16'd0) begin
      fails++;
      $display("FAIL reset_x: got %0d want 0", gx[0]);
    end
    tests++;
    if (sp[0] !== 4'd2) begin
      fails++;
      $display("FAIL reset_speed: got %0d want 2", sp[0]);
    end
    tests++;
    if (wr[0] !== 1'b0) begin
      fails++;
      $display("FAIL reset_wrap: got %b want 0", wr[0]);
    end
    tests++;
    if (sp[1] !== 4'd3 || sp[2] !== 4'd14
        || sp[3] !== 4'd0) begin
      fails++;
      $display("FAIL reset_speed_init: got %0d/%0d/%0d want 3/14/0",
               sp[1], sp[2], sp[3]);
    end
  endtask

  task automatic test_wrap600();
    int ex;
    int ew;
    do_reset();
    run_v[0] = 1'b1;
    for (int k = 1; k <= 601; k++) begin
      step();
      ex = (k < 600) ? 2 * k : (k == 600 ? 0 : 2);
      ew = (k == 600) ? 1 : 0;
      tests++;
      if (gx[0] !== 16'(ex) || wr[0] !== 1'(ew)) begin
        fails++;
        $display("FAIL wrap600 k=%0d: got x=%0d w=%b want x=%0d w=%0d",
                 k, gx[0], wr[0], ex, ew);
      end
    end
    run_v[0] = 1'b0;
  endtask

  task automatic test_accel();
    do_reset();
    run_v[0] = 1'b1;
    repeat (999) step();
    tests++;
    if (sp[0] !== 4'd2 || gx[0] !== 16'd798) begin
      fails++;
      $display("FAIL accel_999: got s=%0d x=%0d want s=2 x=798",
               sp[0], gx[0]);
    end
    step();
    tests++;
    if (sp[0] !== 4'd3 || gx[0] !== 16'd800) begin
      fails++;
      $display("FAIL accel_1000: got s=%0d x=%0d want s=3 x=800",
               sp[0], gx[0]);
    end
    step();
    tests++;
    if (gx[0] !== 16'd803) begin
      fails++;
      $display("FAIL accel_1001: got x=%0d want 803", gx[0]);
    end
    run_v[0] = 1'b0;
  endtask

  task automatic test_odd_wrap();
    int seq [5] = '{3, 6, 9, 2, 5};
    do_reset();
    run_v[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      tests++;
      if (gx[1] !== 16'(seq[k])
          || wr[1] !== 1'(k == 3)) begin
        fails++;
        $display("FAIL odd_wrap k=%0d: got x=%0d w=%b want x=%0d w=%0d",
                 k, gx[1], wr[1], seq[k], (k == 3));
      end
    end
    run_v[1] = 1'b0;
  endtask

  task automatic test_pause();
    do_reset();
    run_v[0] = 1'b1;
    repeat (5) step();
    run_v[0] = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      tests++;
      if (gx[0] !== 16'd10 || wr[0] !== 1'b0
          || sp[0] !== 4'd2) begin
        fails++;
        $display("FAIL pause k=%0d: got x=%0d w=%b s=%0d want 10/0/2",
                 k, gx[0], wr[0], sp[0]);
      end
    end
    run_v[0] = 1'b1;
    step();
    tests++;
    if (gx[0] !== 16'd12) begin
      fails++;
      $display("FAIL pause_resume: got x=%0d want 12", gx[0]);
    end
    repeat (993) step();
    tests++;
    if (sp[0] !== 4'd2) begin
      fails++;
      $display("FAIL pause_accel_999: got s=%0d want 2", sp[0]);
    end
    step();
    tests++;
    if (sp[0] !== 4'd3) begin
      fails++;
      $display("FAIL pause_accel_1000: got s=%0d want 3", sp[0]);
    end
    run_v[0] = 1'b0;
  endtask

  task automatic test_saturation();
    int ex;
    do_reset();
    run_v[2] = 1'b1;
    ex = 0;
    for (int k = 1; k <= 200; k++) begin
      step();
      ex = (ex + ((k == 1) ? 14 : 15)) % 1200;
      tests++;
      if (sp[2] !== 4'd15 || gx[2] !== 16'(ex)
          || gx[2] >= 16'd1200) begin
        fails++;
        $display("FAIL saturation k=%0d: got s=%0d x=%0d want s=15 x=%0d",
                 k, sp[2], gx[2], ex);
      end
    end
    run_v[2] = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_v[0] = 1'b1;
    repeat (1500) step();
    rst_v[0] = 1'b1;
    step();
    rst_v[0] = 1'b0;
    tests++;
    if (gx[0] !== 16'd0 || sp[0] !== 4'd2
        || wr[0] !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got x=%0d s=%0d w=%b want 0/2/0",
               gx[0], sp[0], wr[0]);
    end
    step();
    tests++;
    if (gx[0] !== 16'd2) begin
      fails++;
      $display("FAIL reset_mid_step: got x=%0d want 2", gx[0]);
    end
    run_v[0] = 1'b0;
  endtask

  task automatic test_random();
    int dl [2] = '{0, 3};
    int d;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      foreach (dl[j]) begin
        d = dl[j];
        rst_v[d] = ($urandom % 200) == 0;
        run_v[d] = ($urandom % 4) != 0;
      end
      step();
      foreach (dl[j]) begin
        d = dl[j];
        tests++;
        if (gx[d] !== 16'(mx[d])
            || sp[d] !== 4'(m_speed(d, mt[d]))
            || wr[d] !== 1'(mw[d])) begin
          fails++;
          $display("FAIL random d%0d i%0d: got x=%0d s=%0d w=%b want x=%0d s=%0d w=%0d",
                   d, i, gx[d], sp[d], wr[d],
                   mx[d], m_speed(d, mt[d]), mw[d]);
        end
      end
    end
    foreach (dl[j]) begin
      rst_v[dl[j]] = 1'b0;
      run_v[dl[j]] = 1'b0;
    end
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      rst_v[d] = 1'b1;
      run_v[d] = 1'b0;
      mx[d] = 0; mt[d] = 0; mw[d] = 0;
    end
    #2;
    test_reset();
    test_wrap600();
    test_accel();
    test_odd_wrap();
    test_pause();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
